// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: direction and end-of-range mode encodings.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/count_reg.sv
// WIDTH-bit D register with synchronous active-high reset to a parameterised value.
module count_reg #(
    parameter int unsigned          WIDTH     = 3,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter modulo MODULUS with wrap/saturate mode, parallel load and pulse flags.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 3,
    parameter longint unsigned MODULUS   = 8,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must be in 2..2^WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("updown_mod_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             load_err_d;
    logic [1:0]       flags_q;

    // Any value above MAX_VAL is out of range; with MODULUS = 2^WIDTH nothing is.
    always_comb begin
        count_d    = count;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_val > MAX_VAL) begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (count != MAX_VAL) begin
                    count_d = count + WIDTH'(1);
                end else if (sat == MODE_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_d = count - WIDTH'(1);
                end else if (sat == MODE_WRAP) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    assign tc = en & ((up_dn == DIR_UP) ? (count == MAX_VAL) : (count == '0));

    count_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RST_VAL)
    ) u_count_reg (
        .clk  (clk),
        .reset(reset),
        .d    (count_d),
        .q    (count)
    );

    count_reg #(
        .WIDTH    (2),
        .RESET_VAL(2'b00)
    ) u_flag_reg (
        .clk  (clk),
        .reset(reset),
        .d    ({wrap_d, load_err_d}),
        .q    (flags_q)
    );

    assign wrap     = flags_q[1];
    assign load_err = flags_q[0];

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: two counter instances (modulo 10 and plain binary modulo 8) share one stimulus.
module tb_updown_mod_counter;

    localparam int MOD_A = 10;
    localparam int RV_A  = 2;
    localparam int MOD_B = 8;
    localparam int RV_B  = 0;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, sat, load;
    logic [3:0] load_val;
    logic [3:0] count_a;
    logic       tc_a, wrap_a, lerr_a;
    logic [2:0] count_b;
    logic       tc_b, wrap_b, lerr_b;

    typedef struct {
        int ca; bit wa; bit la;
        int cb; bit wb; bit lb;
    } exp_t;
    typedef struct { bit ta; bit tb; } tc_t;

    exp_t st_q[$];
    tc_t  tc_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ma, mb;
    bit   m_valid  = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(MOD_A), .RESET_VAL(RV_A)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val), .count(count_a), .tc(tc_a), .wrap(wrap_a), .load_err(lerr_a)
    );

    updown_mod_counter u_dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val[2:0]), .count(count_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic over the range 0..m-1.
    function automatic void model_next(input int m, input int rv, input int cur, input bit r,
                                       input bit l, input int lv, input bit e, input bit ud,
                                       input bit s, output int nxt, output bit w, output bit le);
        nxt = cur; w = 0; le = 0;
        if (r) nxt = rv;
        else if (l) begin
            if (lv >= m) begin nxt = m - 1; le = 1; end
            else nxt = lv;
        end else if (e) begin
            if (ud) begin
                if (cur + 1 < m) nxt = cur + 1;
                else if (!s) begin nxt = 0; w = 1; end
            end else begin
                if (cur - 1 >= 0) nxt = cur - 1;
                else if (!s) begin nxt = m - 1; w = 1; end
            end
        end
    endfunction

    task automatic step(input bit r, input bit l, input int lv, input bit e, input bit ud,
                        input bit s);
        exp_t x;
        tc_t  t;
        @(negedge clk);
        reset = r; load = l; load_val = 4'(lv); en = e; up_dn = ud; sat = s;
        if (m_valid) begin
            t.ta = e && (ud ? (ma == MOD_A - 1) : (ma == 0));
            t.tb = e && (ud ? (mb == MOD_B - 1) : (mb == 0));
            tc_q.push_back(t);
        end
        model_next(MOD_A, RV_A, ma, r, l, lv, e, ud, s, x.ca, x.wa, x.la);
        model_next(MOD_B, RV_B, mb, r, l, lv % 8, e, ud, s, x.cb, x.wb, x.lb);
        ma = x.ca;
        mb = x.cb;
        m_valid = m_valid | r;
        st_q.push_back(x);
    endtask

    initial begin : state_monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                x = st_q.pop_front();
                chk("count_a", int'(count_a), x.ca);
                chk("wrap_a", int'(wrap_a), int'(x.wa));
                chk("load_err_a", int'(lerr_a), int'(x.la));
                chk("count_b", int'(count_b), x.cb);
                chk("wrap_b", int'(wrap_b), int'(x.wb));
                chk("load_err_b", int'(lerr_b), int'(x.lb));
            end
        end
    end

    initial begin : tc_monitor
        tc_t t;
        forever begin
            @(negedge clk);
            #2;
            if (tc_q.size() > 0) begin
                t = tc_q.pop_front();
                chk("tc_a", int'(tc_a), int'(t.ta));
                chk("tc_b", int'(tc_b), int'(t.tb));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1; load = 0; load_val = 0; en = 0; up_dn = 0; sat = 0;
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        // Counting down through zero in wrap mode.
        repeat (10) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (11) step(0, 0, 0, 1, 1, 0);
        // Saturate at the top, then reverse direction immediately.
        step(0, 1, 9, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        repeat (2) step(0, 0, 0, 1, 0, 1);
        // Out-of-range load, then load concurrent with enable.
        step(0, 1, 12, 0, 1, 0);
        step(0, 1, 5, 1, 1, 0);
        step(0, 1, 15, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Reset wins over load and enable.
        step(0, 1, 5, 0, 1, 0);
        step(1, 1, 7, 1, 1, 0);
        // Hold with enable low while direction toggles.
        step(0, 1, 3, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, i[0], i[1]);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7,
                 1'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("queues_drained", st_q.size() + tc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: counter width in bits, legal range 1..32.
REQ-002 The block SHALL have parameter MODULUS, default 8: count range is 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 The block SHALL have parameter RESET_VAL, default 0: count value after reset, legal range below MODULUS.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable.
REQ-007 The block SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-008 The block SHALL have port sat, input, 1 bit: mode, 1 = saturate at the ends, 0 = wrap modulo MODULUS.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 The block SHALL have port count, output, WIDTH bits: current count, registered.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal count, combinational from registered state and inputs.
REQ-013 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a wrap.
REQ-014 The block SHALL have port load_err, output, 1 bit: registered one-cycle pulse marking an out-of-range load.

Function
REQ-015 Per-edge priority SHALL be: reset > load > en > hold.
REQ-016 When load=1 and load_val < MODULUS, count SHALL take load_val on the next edge, and load_err SHALL be 0.
REQ-017 When load=1 and load_val >= MODULUS, count SHALL take MODULUS-1 and load_err SHALL be 1 for exactly the next cycle.
REQ-018 With en=1, up_dn=1 and count < MODULUS-1, count SHALL increment by 1 per edge (latency 1 cycle).
REQ-019 With en=1, up_dn=0 and count > 0, count SHALL decrement by 1 per edge.
REQ-020 Up-boundary: with en=1, up_dn=1, count = MODULUS-1: sat=0 -> next count 0 and wrap=1 next cycle; sat=1 -> count holds and wrap stays 0.
REQ-021 Down-boundary: with en=1, up_dn=0, count = 0: sat=0 -> next count MODULUS-1 and wrap=1 next cycle; sat=1 -> count holds and wrap stays 0.
REQ-022 tc SHALL be 1 exactly when en=1 and count is at the boundary for the current up_dn (MODULUS-1 when up, 0 when down), regardless of sat.
REQ-023 With en=0 and load=0, count SHALL hold and wrap and load_err SHALL be 0.
REQ-024 load=1 together with en=1 SHALL perform only the load; no wrap SHALL be reported that cycle.
REQ-025 up_dn and sat SHALL be sampled each edge; a direction change SHALL take effect on the very next edge with no dead cycle.
REQ-026 wrap and load_err SHALL be 0 in every cycle not named in REQ-017, REQ-020 and REQ-021.
REQ-027 When MODULUS = 2^WIDTH, behaviour SHALL match plain binary wrap, with no extra comparison slack.

Reset
REQ-028 On a clk edge with reset=1, count SHALL become RESET_VAL, and wrap and load_err SHALL become 0.
REQ-029 Reset SHALL override load and en in the same cycle, and reset asserted mid-count SHALL discard the in-progress value.
REQ-030 tc SHALL follow REQ-022 from the reset value in the first cycle after reset.

Structure
REQ-031 Shared package counter_pkg SHALL hold the direction constants (DIR_UP=1, DIR_DN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-032 Next-state logic SHALL be a single combinational block computing next count, wrap and load_err.
REQ-033 State SHALL be held in one sub-module, count_reg: a WIDTH-bit D register with synchronous active-high reset and parameterised reset value.
REQ-034 Parameter legality (REQ-002, REQ-003) SHALL be checked at elaboration and SHALL fail the build if violated.

Verification
REQ-035 Default parameters, reset, en=1, up_dn=0, sat=0 for 10 cycles -> count 0,7,6,5,4,3,2,1,0,7; wrap pulses in the cycles where count becomes 7.
REQ-036 MODULUS=10, WIDTH=4, up, sat=0, from 0 -> count reaches 9 with tc=1, then 0 with wrap=1 for 1 cycle.
REQ-037 MODULUS=10, up, sat=1 at 9 for 3 cycles -> count stays 9, tc=1, wrap=0; then switch to up_dn=0 -> 8 on next edge.
REQ-038 MODULUS=10, load=1, load_val=12 -> count=9 and load_err=1 for one cycle; then load_val=5 together with en=1 -> count=5 and no wrap.
REQ-039 Reset asserted at count=5 together with load=1 and en=1 -> count=RESET_VAL, wrap=0, load_err=0 on the next edge.
REQ-040 en=0 for 5 cycles at count=3 with up_dn toggling -> count stays 3, tc=0, no pulses.
